// File: rtl/uart_axis_bridge.sv
// UART (8N1) to AXI-Stream bridge: RX bytes land in a small FIFO feeding m_axis,
// s_axis bytes are serialised onto uart_tx_o. RX and TX run independently.
module uart_axis_bridge #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx_i,
  output logic       uart_tx_o,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic       rx_frame_err_o,
  output logic       rx_overrun_o,
  output logic       tx_busy_o
);

  // Handshakes: a beat transfers on a rising edge where valid && ready are both high;
  // the head byte and valid stay stable while valid is high and ready is low.

  localparam int BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W      = $clog2(BIT_CYCLES) + 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(BIT_CYCLES);
  localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(BIT_CYCLES / 2);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign m_axis_tlast = 1'b0;

  // ---------------- RX path ----------------
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             ferr_q, ferr_d, ovr_q, ovr_d;
  logic             rx_push, fifo_pop, fifo_full;

  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  assign m_axis_tvalid  = (count_q != '0);
  assign m_axis_tdata   = fifo_mem_q[rd_ptr_q];
  assign fifo_pop       = m_axis_tvalid && m_axis_tready;
  assign fifo_full      = (count_q == DEPTH_C);
  assign rx_frame_err_o = ferr_q;
  assign rx_overrun_o   = ovr_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = BIT_HALF;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_W'(1)) begin
          // A line already back high at mid-start is a glitch, not a frame.
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          rx_cnt_d   = BIT_FULL;
          rx_idx_d   = 3'd0;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_W'(1)) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_FULL;
          rx_idx_d   = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_W'(1)) begin
          rx_state_d = RX_IDLE;
          if (!rx_sync_q)                  ferr_d  = 1'b1;
          else if (fifo_full && !fifo_pop) ovr_d   = 1'b1;
          else                             rx_push = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = rx_push  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = fifo_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (rx_push && !fifo_pop)      count_d = count_q + (PTR_W + 1)'(1);
    else if (!rx_push && fifo_pop) count_d = count_q - (PTR_W + 1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else begin
      rx_meta_q  <= uart_rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (rx_push) fifo_mem_q[wr_ptr_q] <= rx_shift_q;
    end
  end

  // ---------------- TX path ----------------
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_rdy_q, tx_rdy_d;
  logic             tx_busy_q, tx_busy_d;

  assign uart_tx_o     = tx_line_q;
  assign s_axis_tready = tx_rdy_q;
  assign tx_busy_o     = tx_busy_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        if (s_axis_tvalid && tx_rdy_q) begin
          tx_state_d = TX_START;
          tx_shift_d = s_axis_tdata;
          tx_cnt_d   = BIT_FULL;
          tx_line_d  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_W'(1)) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = BIT_FULL;
          tx_idx_d   = 3'd0;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_W'(1)) begin
          tx_cnt_d = BIT_FULL;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_W'(1)) tx_state_d = TX_IDLE;
        else                       tx_cnt_d   = tx_cnt_q - CNT_W'(1);
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Ready/busy are registered from the next state so reset holds ready low.
    tx_rdy_d  = (tx_state_d == TX_IDLE);
    tx_busy_d = (tx_state_d != TX_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_rdy_q   <= 1'b0;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      tx_rdy_q   <= tx_rdy_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

endmodule
